// File: rtl/display_pkg.sv
// Shared constants and helpers for the seven-segment display datapath.
package display_pkg;

  localparam int DIGITS_DEFAULT   = 8;
  localparam int SCAN_DIV_DEFAULT = 100000;
  localparam int NIBBLE_W         = 4;
  localparam int MAX_DIGITS       = 8;

  // Active-low anode pattern with only bit idx pulled low; callers slice to DIGITS.
  function automatic logic [MAX_DIGITS-1:0] onehot_low(input logic [2:0] idx);
    logic [MAX_DIGITS-1:0] one;
    one = MAX_DIGITS'(1);
    return ~(one << idx);
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Modulo-DIV free-running counter producing a registered one-cycle tick on the last count.
module scan_prescaler #(
  parameter int DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = (cnt_reg == LAST) ? '0 : cnt_reg + CNT_W'(1);
  end

  // tick is registered from cnt_next so it is high exactly while cnt_reg == LAST.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
      tick    <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      tick    <= (cnt_next == LAST);
    end
  end

endmodule

// File: rtl/segment_scanner.sv
// Time-multiplexed 7-segment digit scanner with shadow register and leading-zero blanking.
module segment_scanner
  import display_pkg::*;
#(
  parameter int DIGITS   = DIGITS_DEFAULT,
  parameter int SCAN_DIV = SCAN_DIV_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic [NIBBLE_W*DIGITS-1:0] data,
  input  logic                       lz_en,
  output logic [NIBBLE_W-1:0]        int_data,
  output logic [DIGITS-1:0]          anode,
  output logic                       tick
);

  localparam int IDX_W  = $clog2(DIGITS);
  localparam int DATA_W = NIBBLE_W * DIGITS;
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] ANODE_RST  = {{(DIGITS-1){1'b1}}, 1'b0};

  logic [DATA_W-1:0]   shadow_reg;
  logic [IDX_W-1:0]    idx_reg;
  logic [IDX_W-1:0]    idx_next;
  logic [IDX_W-1:0]    msd;
  logic [NIBBLE_W-1:0] nibble [DIGITS];
  logic [DIGITS-1:0]   nibble_nz;
  logic                suppress;
  logic [MAX_DIGITS-1:0] anode_pat;

  scan_prescaler #(
    .DIV (SCAN_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_nibble
      assign nibble[gi]    = shadow_reg[gi*NIBBLE_W +: NIBBLE_W];
      assign nibble_nz[gi] = |shadow_reg[gi*NIBBLE_W +: NIBBLE_W];
    end
  endgenerate

  // Highest nonzero digit wins; an all-zero word leaves msd at 0 so digit 0 stays lit.
  always_comb begin
    msd = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (nibble_nz[i]) msd = IDX_W'(i);
    end
  end

  always_comb begin
    idx_next = idx_reg;
    if (tick) idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
  end

  assign suppress  = lz_en && (idx_next > msd);
  assign anode_pat = onehot_low(3'(idx_next));

  // Outputs are driven from the pre-load shadow, so a load shows up one edge later.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_reg <= '0;
      idx_reg    <= '0;
      int_data   <= '0;
      anode      <= ANODE_RST;
    end else begin
      if (load) shadow_reg <= data;
      idx_reg <= idx_next;
      if (suppress) begin
        int_data <= '0;
        anode    <= '1;
      end else begin
        int_data <= nibble[idx_next];
        anode    <= anode_pat[DIGITS-1:0];
      end
    end
  end

endmodule

// File: tb/tb_segment_scanner.sv
// Randomized + directed bench for segment_scanner against a time-based behavioural model.
module tb_segment_scanner;

  localparam int DIGITS = 8;
  localparam int DIV    = 4;
  localparam int FRAME  = DIGITS * DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [31:0] data;
  logic        lz_en;
  logic [3:0]  int_data;
  logic [7:0]  anode;
  logic        tick;

  int vectors    = 0;
  int miscompares = 0;

  // Model: t = cycles since the reset edge; digit and tick follow from t by arithmetic.
  int          t = 0;
  logic [31:0] m_shadow = '0;
  logic [7:0]  m_anode  = 8'hFE;
  logic [3:0]  m_int    = '0;
  logic        m_tick   = 1'b0;

  segment_scanner #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .data     (data),
    .lz_en    (lz_en),
    .int_data (int_data),
    .anode    (anode),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  function automatic int msd_of(input logic [31:0] s);
    int m = 0;
    for (int i = 0; i < DIGITS; i++) if (s[i*4 +: 4] != 4'h0) m = i;
    return m;
  endfunction

  task automatic model_edge(input logic r, input logic ld, input logic [31:0] d, input logic lz);
    int dig;
    logic [7:0] one;
    if (r) begin
      t = 0; m_shadow = '0; m_anode = 8'hFE; m_int = '0; m_tick = 1'b0;
    end else begin
      t++;
      dig = (t / DIV) % DIGITS;
      one = 8'h01;
      if (lz && dig > msd_of(m_shadow)) begin
        m_anode = 8'hFF; m_int = 4'h0;
      end else begin
        m_anode = ~(one << dig); m_int = m_shadow[dig*4 +: 4];
      end
      m_tick = ((t % DIV) == DIV - 1);
      if (ld) m_shadow = d;
    end
  endtask

  task automatic cycle(input logic r, input logic ld, input logic [31:0] d, input logic lz);
    rst = r; load = ld; data = d; lz_en = lz;
    @(posedge clk);
    model_edge(r, ld, d, lz);
    #1;
    check("anode", 32'(anode), 32'(m_anode));
    check("int_data", 32'(int_data), 32'(m_int));
    check("tick", 32'(tick), 32'(m_tick));
    check("one_low", 32'($countones(~anode) <= 1), 32'd1);
    if (ld && !r) $display("load data=%h lz_en=%0d t=%0d anode=%h int_data=%h", d, lz, t, anode, int_data);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    int first_tick;
    int guard;
    logic lz;
    rst = 1'b1; load = 1'b0; data = '0; lz_en = 1'b0;
    @(negedge clk);

    // Reset values and first tick position.
    do_reset(3);
    check("rst_anode", 32'(anode), 32'h0000_00FE);
    check("rst_int", 32'(int_data), 32'h0);
    first_tick = 0;
    for (int i = 1; i <= 20 && first_tick == 0; i++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b0);
      if (tick) first_tick = i;
    end
    check("first_tick_cycle", 32'(first_tick), 32'd3);
    $display("reset: first tick seen %0d edges after the reset edge", first_tick);

    // Scan order with all digits distinct.
    do_reset(1);
    cycle(1'b0, 1'b1, 32'h76543210, 1'b0);
    for (int i = 0; i < FRAME + 8; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0);

    // Leading-zero suppression, then an all-zero word.
    do_reset(1);
    cycle(1'b0, 1'b1, 32'h000000A5, 1'b1);
    for (int i = 0; i < FRAME + 4; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b1, 32'h0, 1'b1);
    for (int i = 0; i < FRAME + 4; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);

    // Load coinciding with a tick edge: old shadow on that edge, new value next edge.
    do_reset(1);
    guard = 0;
    while (!m_tick && guard < 50) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b0);
      guard++;
    end
    check("tick_found", 32'(m_tick), 32'd1);
    cycle(1'b0, 1'b1, 32'hFFFFFFFF, 1'b0);
    check("ltick_old", 32'(int_data), 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    check("ltick_new", 32'(int_data), 32'hF);

    // Reset mid-scan at digit 5, count 2.
    cycle(1'b0, 1'b1, 32'h89ABCDEF, 1'b0);
    guard = 0;
    while ((t % FRAME) != 5 * DIV + 2 && guard < 100) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b0);
      guard++;
    end
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    check("midrst_anode", 32'(anode), 32'h0000_00FE);
    for (int i = 0; i < FRAME + 4; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    check("midrst_shadow_zero", 32'(int_data), 32'h0);

    // Random soak.
    lz = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 63) == 0) lz = ~lz;
      if ($urandom_range(0, 15) == 0)
        cycle(1'b0, 1'b1, ($urandom_range(0, 1) == 1) ? ($urandom() >> (4 * $urandom_range(0, 7))) : $urandom(), lz);
      else
        cycle(1'b0, 1'b0, $urandom(), lz);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
